mem_load_u: RTL and testbench
=============================

# mem_load_U

Sprite-buffer loader: accepts a width×height pixel stream over a valid/ready handshake and writes it into the 27000-word sprite memory. Rows are stored bottom-aligned in a 450-row sheet, so the address for pixel (x, y) is x + width·(y + 450 − height) mod 27000. This is exactly the layout the display-side address generator reads back. The loader sits between the image source (UART/ROM streamer) and the write port of the sprite block RAM. It stalls while the display side owns the memory.

## Interface
- DW, 12, pixel data width
- AW, 17, memory address width
- ROWS, 450, sheet height in rows
- DEPTH, 27000, memory depth in words; address space wraps modulo DEPTH
- clk  in  1  system clock
- rst  in  1  reset; one clock; reset is asynchronous and active-low
- start  in  1  one-cycle load request; sampled only in IDLE
- width  in  10  sprite width in pixels; latched on accepted start
- height  in  10  sprite height in rows; latched on accepted start
- pix_data  in  DW  streamed pixel, row-major order, x fastest
- pix_valid  in  1  pix_data valid
- pix_ready  out  1  loader can accept a pixel this cycle
- hold  in  1  memory owned by the reader; blocks acceptance
- we  out  1  memory write enable
- waddr  out  AW  memory write address
- wdata  out  DW  memory write data
- busy  out  1  load in progress
- done  out  1  one-cycle pulse on the final write
- err  out  1  one-cycle pulse when start is rejected

## Operation
- States: IDLE, LOAD.
- IDLE, start=1:
  - Latch W=width and H=height.
  - Reject if W==0, H==0, H>ROWS, or W·ROWS>DEPTH (W>60). On reject: err=1 next cycle, stay IDLE.
  - Otherwise: addr=W·(ROWS−H) (17-bit product, no truncation), x=0, y=0, go to LOAD.
- LOAD:
  - pix_ready = !hold (combinational from state and hold only, never from pix_valid).
  - Transfer occurs when pix_valid && pix_ready.
  - On transfer: write addr/pix_data; addr ← (addr==DEPTH−1) ? 0 : addr+1; x ← x+1.
  - At the end of a row (x==W−1): x ← 0, y ← y+1.
  - Transfer with x==W−1 and y==H−1 is the last pixel; return to IDLE.
- start in LOAD is ignored (no err, no relatch). width/height changes during LOAD have no effect.
- hold during LOAD stalls only; x, y, addr are retained.
- Reset (any time, including mid-load): return to IDLE, clear counters, drop all outputs. A partially written sprite is not cleaned up.

## Timing
- Reset values: pix_ready=0, we=0, waddr=0, wdata=0, busy=0, done=0, err=0.
- we/waddr/wdata are registered: asserted the cycle after the transfer, for one cycle per pixel. Back-to-back transfers give we high on consecutive cycles with contiguous addresses.
- done is high in the same cycle as the final we.
- busy goes high the cycle after an accepted start. It stays high through the cycle carrying the final we, then drops.
- pix_ready goes high the cycle after an accepted start if hold=0. It is low in the cycle after the last transfer.
- err is high the cycle after a rejected start, for 1 cycle.
- The next start is accepted no earlier than the cycle in which busy has dropped to 0.
- Throughput: 1 pixel/cycle when pix_valid=1 and hold=0.
- Worst-case load length: 27000 transfers.

## Test plan
- W=4, H=2, continuous valid, data 1..8 → base 4·448=1792; we on 8 consecutive cycles with waddr 1792..1799 and wdata 1..8; done coincides with waddr=1799; busy spans from the cycle after start through the cycle of the last we.
- Same load with hold=1 for 3 cycles after the 3rd transfer → pix_ready=0 and no we for those 3 cycles; the 4th pixel resumes at waddr 1795; final waddr still 1799.
- Reject cases, each with start=1 and no busy: width=0 → err pulse; height=451 → err pulse; width=61 → err pulse.
- W=60, H=450 full sheet → base 0; final waddr 26999; done=1 there; then busy=0.
- start pulsed mid-load with different width → ignored; addresses continue the original sequence; no err.
- rst=0 asserted after the 5th transfer of W=4, H=2 → all outputs 0 immediately. After release, a new start with W=2, H=1 writes waddr 898, 899 (2·449=898).

Source files
------------

// File: rtl/mem_load_u.sv
`default_nettype none
// ============================================================================
// Module      : mem_load_u
// Description : Sprite-buffer loader. Accepts a width x height pixel stream
//               over a valid/ready handshake and writes it, bottom-aligned in
//               a ROWS-row sheet, into the sprite memory write port.
//               Address of pixel (x, y) = x + W*(y + ROWS - H) mod DEPTH.
// Ports       : clk        - system clock
//               rst        - asynchronous active-low reset
//               start      - one-cycle load request (sampled in IDLE only)
//               width      - sprite width in pixels (latched on accept)
//               height     - sprite height in rows (latched on accept)
//               pix_data   - streamed pixel, row-major, x fastest
//               pix_valid  - pix_data valid
//               pix_ready  - loader accepts a pixel this cycle
//               hold       - reader owns the memory; blocks acceptance
//               we/waddr/wdata - registered memory write port
//               busy       - load in progress
//               done       - one-cycle pulse with the final write
//               err        - one-cycle pulse when start is rejected
// Revision    : 1.0 - initial release
// ============================================================================
module mem_load_u #(
  parameter int DW    = 12,
  parameter int AW    = 17,
  parameter int ROWS  = 450,
  parameter int DEPTH = 27000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [9:0]    width,
  input  logic [9:0]    height,
  input  logic [DW-1:0] pix_data,
  input  logic          pix_valid,
  output logic          pix_ready,
  input  logic          hold,
  output logic          we,
  output logic [AW-1:0] waddr,
  output logic [DW-1:0] wdata,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam logic [0:0]    S_IDLE      = 1'b0;
  localparam logic [0:0]    S_LOAD      = 1'b1;
  localparam logic [31:0]   c_rows      = 32'(ROWS);
  localparam logic [31:0]   c_depth     = 32'(DEPTH);
  localparam logic [AW-1:0] c_last_addr = AW'(DEPTH - 1);
  localparam logic [AW-1:0] c_addr_one  = AW'(1);

  logic [0:0]    r_state;
  logic [0:0]    w_next_state;
  logic [9:0]    r_w;
  logic [9:0]    r_h;
  logic [9:0]    r_x;
  logic [9:0]    r_y;
  logic [AW-1:0] r_addr;
  logic          r_we;
  logic [AW-1:0] r_waddr;
  logic [DW-1:0] r_wdata;
  logic          r_done;
  logic          r_err;

  logic [31:0]   w_width32;
  logic [31:0]   w_height32;
  logic [31:0]   w_sheet;
  logic [AW-1:0] w_base;
  logic          w_bad_dims;
  logic          w_start_seen;
  logic          w_accept;
  logic          w_reject;
  logic          w_xfer;
  logic          w_row_end;
  logic          w_last;

  assign w_width32  = 32'(width);
  assign w_height32 = 32'(height);
  // Full-sheet footprint must fit the memory: W*ROWS <= DEPTH.
  assign w_sheet    = w_width32 * c_rows;
  // Only meaningful when height <= ROWS; otherwise the start is rejected.
  assign w_base     = AW'(w_width32 * (c_rows - w_height32));
  assign w_bad_dims = (width == 10'd0) || (height == 10'd0) ||
                      (w_height32 > c_rows) || (w_sheet > c_depth);

  // The cycle carrying the final write is already IDLE but still busy; a
  // start there is not honoured so the next load begins only once busy=0.
  assign w_start_seen = (r_state == S_IDLE) && start && !r_done;
  assign w_accept     = w_start_seen && !w_bad_dims;
  assign w_reject     = w_start_seen &&  w_bad_dims;

  assign w_xfer    = (r_state == S_LOAD) && pix_valid && !hold;
  assign w_row_end = (r_x == r_w - 10'd1);
  assign w_last    = w_row_end && (r_y == r_h - 10'd1);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: if (w_accept)          w_next_state = S_LOAD;
      S_LOAD: if (w_xfer && w_last)  w_next_state = S_IDLE;
      default:                       w_next_state = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    pix_ready = (r_state == S_LOAD) && !hold;
    busy      = (r_state == S_LOAD) || r_done;
    we        = r_we;
    waddr     = r_waddr;
    wdata     = r_wdata;
    done      = r_done;
    err       = r_err;
  end

  // Geometry, counters and registered write port
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_w     <= '0;
      r_h     <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_we   <= 1'b0;
      r_done <= 1'b0;
      r_err  <= w_reject;
      if (w_accept) begin
        r_w    <= width;
        r_h    <= height;
        r_x    <= '0;
        r_y    <= '0;
        r_addr <= w_base;
      end else if (w_xfer) begin
        r_we    <= 1'b1;
        r_waddr <= r_addr;
        r_wdata <= pix_data;
        r_done  <= w_last;
        r_addr  <= (r_addr == c_last_addr) ? '0 : r_addr + c_addr_one;
        if (w_row_end) begin
          r_x <= '0;
          r_y <= r_y + 10'd1;
        end else begin
          r_x <= r_x + 10'd1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_load_u.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_mem_load_u
// Description : Self-checking bench for mem_load_u. Table of load vectors
//               plus randomized loads; expected writes come from the sheet
//               address rule applied to a pixel index.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_load_u;

  localparam int DW    = 12;
  localparam int AW    = 17;
  localparam int ROWS  = 450;
  localparam int DEPTH = 27000;

  logic          clk       = 1'b0;
  logic          rst       = 1'b0;
  logic          start     = 1'b0;
  logic [9:0]    width     = '0;
  logic [9:0]    height    = '0;
  logic [DW-1:0] pix_data  = '0;
  logic          pix_valid = 1'b0;
  logic          hold      = 1'b0;
  logic          pix_ready;
  logic          we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic          busy;
  logic          done;
  logic          err;

  int errors = 0;
  int checks = 0;

  mem_load_u #(.DW(DW), .AW(AW), .ROWS(ROWS), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .width     (width),
    .height    (height),
    .pix_data  (pix_data),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .hold      (hold),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int w;
    int h;
    int valid_pct;
    int hold_mode;   // 0: random hold at hold_pct, 1: 3-cycle hold after 3rd pixel
    int hold_pct;
    bit seq_data;    // pixel data = 1,2,3,... instead of random
    bit mid_start;   // pulse start (with junk width) during the load
    bit exp_err;
    int exp_base;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic bit rule_reject(input int w, input int h);
    return (w == 0) || (h == 0) || (h > ROWS) || (w * ROWS > DEPTH);
  endfunction

  // Issue a start at the current negedge and follow the whole load.
  task automatic run_load(input vec_t v);
    int total, n, hold_cnt, cyc, x, y, exp_addr, exp_data;
    bit loading, have_exp, exp_done, first;
    start  = 1'b1;
    width  = 10'(v.w);
    height = 10'(v.h);
    @(negedge clk);
    start  = 1'b0;
    width  = 10'($urandom_range(0, 1023));
    height = 10'($urandom_range(0, 1023));
    chk("err_after_start", {31'd0, err}, {31'd0, v.exp_err});
    chk("busy_after_start", {31'd0, busy}, {31'd0, !v.exp_err});
    if (v.exp_err) begin
      chk("ready_after_reject", {31'd0, pix_ready}, 32'd0);
      @(negedge clk);
      chk("err_one_cycle", {31'd0, err}, 32'd0);
      chk("busy_after_reject", {31'd0, busy}, 32'd0);
      return;
    end
    total = v.w * v.h; n = 0; hold_cnt = 0; cyc = 0;
    loading = 1'b1; have_exp = 1'b0; exp_done = 1'b0; first = 1'b1;
    exp_addr = 0; exp_data = 0;
    while ((loading || have_exp) && cyc < 60000) begin
      // Outputs produced by the previous rising edge
      chk("busy", {31'd0, busy}, 32'd1);
      chk("we", {31'd0, we}, {31'd0, have_exp});
      chk("done", {31'd0, done}, {31'd0, have_exp && exp_done});
      chk("err_quiet", {31'd0, err}, 32'd0);
      if (have_exp) begin
        chk("waddr", 32'(waddr), 32'(exp_addr));
        chk("wdata", 32'(wdata), 32'(exp_data));
        if (first) begin
          chk("base_addr", 32'(waddr), 32'(v.exp_base));
          first = 1'b0;
        end
      end
      // Inputs for the next rising edge
      if (loading) begin
        pix_valid = ($urandom_range(0, 99) < v.valid_pct);
        if (v.hold_mode == 1) begin
          hold = (n == 3) && (hold_cnt < 3);
          if (hold) hold_cnt++;
        end else begin
          hold = ($urandom_range(0, 99) < v.hold_pct);
        end
        pix_data = v.seq_data ? DW'(n + 1) : DW'($urandom);
        start    = v.mid_start && ($urandom_range(0, 15) == 0);
        width    = 10'($urandom_range(0, 1023));
      end else begin
        pix_valid = 1'b0;
        hold      = 1'b0;
        start     = 1'b0;
      end
      #1;
      chk("pix_ready", {31'd0, pix_ready}, {31'd0, loading && !hold});
      if (loading && pix_valid && !hold) begin
        x        = n % v.w;
        y        = n / v.w;
        exp_addr = (x + v.w * (y + ROWS - v.h)) % DEPTH;
        exp_data = 32'(pix_data);
        exp_done = (n == total - 1);
        have_exp = 1'b1;
        n++;
        if (n == total) loading = 1'b0;
      end else begin
        have_exp = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 60000) chk("load_timeout", 32'd1, 32'd0);
    chk("busy_end", {31'd0, busy}, 32'd0);
    chk("we_end", {31'd0, we}, 32'd0);
    chk("done_end", {31'd0, done}, 32'd0);
    chk("ready_end", {31'd0, pix_ready}, 32'd0);
  endtask

  vec_t tbl[11];
  vec_t rv;

  initial begin
    //        w   h    vld hm hp seq mid err base
    tbl[0]  = '{4,  2,   100, 0, 0, 1, 0, 0, 1792};
    tbl[1]  = '{4,  2,   100, 1, 0, 1, 0, 0, 1792};
    tbl[2]  = '{0,  5,   100, 0, 0, 0, 0, 1, 0};
    tbl[3]  = '{3,  451, 100, 0, 0, 0, 0, 1, 0};
    tbl[4]  = '{61, 1,   100, 0, 0, 0, 0, 1, 0};
    tbl[5]  = '{4,  0,   100, 0, 0, 0, 0, 1, 0};
    tbl[6]  = '{60, 450, 100, 0, 0, 0, 0, 0, 0};
    tbl[7]  = '{7,  13,  70,  0, 20, 0, 1, 0, 3059};
    tbl[8]  = '{1,  1,   100, 0, 0, 1, 1, 0, 449};
    tbl[9]  = '{60, 1,   80,  0, 10, 0, 1, 0, 26940};
    tbl[10] = '{13, 450, 60,  0, 30, 0, 1, 0, 0};

    // Reset state
    #1;
    chk("rst_ready", {31'd0, pix_ready}, 32'd0);
    chk("rst_we", {31'd0, we}, 32'd0);
    chk("rst_waddr", 32'(waddr), 32'd0);
    chk("rst_wdata", 32'(wdata), 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      run_load(tbl[i]);
      @(negedge clk);
    end

    // Randomized loads, expectations from the acceptance rule
    for (int i = 0; i < 8; i++) begin
      rv.w         = $urandom_range(0, 70);
      rv.h         = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 20)
                                                 : $urandom_range(440, 460);
      if (rv.h > 20 && rv.w > 3 && !rule_reject(rv.w, rv.h)) rv.w = 3;
      rv.valid_pct = $urandom_range(40, 100);
      rv.hold_mode = 0;
      rv.hold_pct  = $urandom_range(0, 40);
      rv.seq_data  = 1'b0;
      rv.mid_start = 1'b1;
      rv.exp_err   = rule_reject(rv.w, rv.h);
      rv.exp_base  = rv.exp_err ? 0 : rv.w * (ROWS - rv.h);
      run_load(rv);
      @(negedge clk);
    end

    // Reset in the middle of a load, after the 5th transfer
    start = 1'b1; width = 10'd4; height = 10'd2;
    @(negedge clk);
    start = 1'b0; pix_valid = 1'b1; hold = 1'b0; pix_data = DW'(7);
    repeat (5) @(posedge clk);
    #1;
    chk("pre_rst_we", {31'd0, we}, 32'd1);
    chk("pre_rst_waddr", 32'(waddr), 32'd1796);
    rst = 1'b0;
    #1;
    chk("mid_rst_ready", {31'd0, pix_ready}, 32'd0);
    chk("mid_rst_we", {31'd0, we}, 32'd0);
    chk("mid_rst_waddr", 32'(waddr), 32'd0);
    chk("mid_rst_wdata", 32'(wdata), 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    chk("mid_rst_err", {31'd0, err}, 32'd0);
    @(negedge clk);
    pix_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rv = '{2, 1, 100, 0, 0, 1, 0, 0, 898};
    run_load(rv);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
